// File: rtl/wisc_pkg.sv
// Shared types for the WISC ID/EX boundary: control bundle layout, FSM encoding, bubble constant.
// Latency: none (types only). Backpressure: n/a.
package wisc_pkg;
  localparam int DW     = 16;
  localparam int RW     = 3;
  localparam int CTRL_W = 20;

  localparam int POS_ERR       = 0;
  localparam int POS_SIIC      = 1;
  localparam int POS_HALT      = 2;
  localparam int POS_ALU_CIN   = 3;
  localparam int POS_ALU_INV_B = 4;
  localparam int POS_ALU_INV_A = 5;
  localparam int POS_REG_TO_PC = 6;
  localparam int POS_PC_TO_REG = 7;
  localparam int POS_MEM_TO_REG = 8;
  localparam int POS_REG_WRITE = 9;
  localparam int POS_MEM_WRITE = 10;
  localparam int POS_MEM_READ  = 11;
  localparam int POS_BRANCH    = 12;
  localparam int POS_JUMP      = 13;
  localparam int POS_ALU_SRC   = 14;
  localparam int POS_ALU_OP    = 16;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] alu_src;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_to_pc;
    logic       alu_inv_a;
    logic       alu_inv_b;
    logic       alu_cin;
    logic       halt;
    logic       siic;
    logic       err;
  } ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_pipe_if.sv
// Decode-side / execute-side instruction bus; the producer uses master, the consumer slave.
// Latency: none (wires). Backpressure: carried separately by stall signals.
interface id_ex_pipe_if;
  import wisc_pkg::*;

  logic            valid;
  ctrl_t           ctrl;
  logic [DW-1:0]   rd1;
  logic [DW-1:0]   rd2;
  logic [DW-1:0]   imm;
  logic [DW-1:0]   pc2;
  logic [RW-1:0]   rs;
  logic [RW-1:0]   rt;
  logic [RW-1:0]   wr;
  logic            rs_used;
  logic            rt_used;

  modport master (output valid, ctrl, rd1, rd2, imm, pc2, rs, rt, wr, rs_used, rt_used);
  modport slave  (input  valid, ctrl, rd1, rd2, imm, pc2, rs, rt, wr, rs_used, rt_used);
endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the register a load in EX will write.
// Latency: combinational. Backpressure: none.
module hazard_detect
  import wisc_pkg::*;
(
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic          ex_reg_write,
  input  logic [RW-1:0] ex_wr,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  output logic          hazard
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_used & (id_rs == ex_wr);
  assign rt_hit = id_rt_used & (id_rt == ex_wr);
  assign hazard = ex_valid & ex_mem_read & ex_reg_write & id_valid & (rs_hit | rt_hit);
endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use bubble, flush, hold and sticky halt; 1-cycle latency.
// stall_i holds EX; stall_o holds PC/IF-ID. Optional illegal-opcode trap under ID_EX_ERR_TRAP_EN.
module id_ex_pipe
  import wisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  id_ex_pipe_if.slave        id,
  id_ex_pipe_if.master       ex,
  input  logic               flush_i,
  input  logic               stall_i,
  output logic               stall_o,
  output logic               halted_o,
  output logic               exc_o
);
  state_t        state_q;
  logic          halted_q;
  logic          valid_q;
  ctrl_t         ctrl_q;
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] rd2_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] pc2_q;
  logic [RW-1:0] rs_q;
  logic [RW-1:0] rt_q;
  logic [RW-1:0] wr_q;
  logic          rs_used_q;
  logic          rt_used_q;

  logic hazard;
  logic load_vld;
  logic trap_now;
  logic halt_now;

  hazard_detect u_hazard (
    .ex_valid     (valid_q),
    .ex_mem_read  (ctrl_q.mem_read),
    .ex_reg_write (ctrl_q.reg_write),
    .ex_wr        (wr_q),
    .id_valid     (id.valid),
    .id_rs        (id.rs),
    .id_rt        (id.rt),
    .id_rs_used   (id.rs_used),
    .id_rt_used   (id.rt_used),
    .hazard       (hazard)
  );

`ifdef ID_EX_ERR_TRAP_EN
  logic exc_q;
  assign trap_now = valid_q & ctrl_q.err;
  assign exc_o    = exc_q;
`else
  assign trap_now = 1'b0;
  assign exc_o    = 1'b0;
`endif

  // Invalid, flushed or hazarded captures all collapse into a zeroed bubble.
  assign load_vld = id.valid & ~flush_i & ~hazard;
  assign halt_now = (valid_q & ctrl_q.halt) | trap_now;
  assign stall_o  = stall_i | (hazard & ~flush_i) | halted_q;
  assign halted_o = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      valid_q   <= 1'b0;
      ctrl_q    <= BUBBLE_CTRL;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      pc2_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_q      <= '0;
      rs_used_q <= 1'b0;
      rt_used_q <= 1'b0;
`ifdef ID_EX_ERR_TRAP_EN
      exc_q     <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      if (halt_now) begin
        // The halting instruction stays frozen in EX from here until reset.
        state_q  <= HALTED;
        halted_q <= 1'b1;
`ifdef ID_EX_ERR_TRAP_EN
        if (trap_now) exc_q <= 1'b1;
`endif
      end else if (!stall_i) begin
        valid_q   <= load_vld;
        ctrl_q    <= load_vld ? id.ctrl : BUBBLE_CTRL;
        rd1_q     <= load_vld ? id.rd1 : '0;
        rd2_q     <= load_vld ? id.rd2 : '0;
        imm_q     <= load_vld ? id.imm : '0;
        pc2_q     <= load_vld ? id.pc2 : '0;
        rs_q      <= load_vld ? id.rs : '0;
        rt_q      <= load_vld ? id.rt : '0;
        wr_q      <= load_vld ? id.wr : '0;
        rs_used_q <= load_vld & id.rs_used;
        rt_used_q <= load_vld & id.rt_used;
      end
    end
  end

  assign ex.valid   = valid_q;
  assign ex.ctrl    = ctrl_q;
  assign ex.rd1     = rd1_q;
  assign ex.rd2     = rd2_q;
  assign ex.imm     = imm_q;
  assign ex.pc2     = pc2_q;
  assign ex.rs      = rs_q;
  assign ex.rt      = rt_q;
  assign ex.wr      = wr_q;
  assign ex.rs_used = rs_used_q;
  assign ex.rt_used = rt_used_q;
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Pipeline register and hazard stage between instruction decode and execute in the 16-bit five-stage WISC pipeline. Captures the decoder's control bundle plus register-file operands each cycle and presents them to EX. Detects load-use hazards, holding IF/ID and injecting a bubble when needed. Also handles branch/jump flushes, downstream backpressure and the sticky halt condition.

## Interface
- DW, 16, datapath width (operands, immediate, PC+2)
- RW, 3, register-index width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  CTRL_W  decoder bundle {ALUOp[3:0], ALUSrc[1:0], Jump, Branch, MemRead, MemWrite, RegWrite, MemToReg, PcToReg, RegToPc, ALU_InvA, ALU_InvB, ALU_Cin, Halt, SIIC, err}
- id_rd1, id_rd2, id_imm, id_pc2  in  DW each  operands, sign-extended immediate, PC+2
- id_rs, id_rt, id_wr  in  RW each  source/destination indices
- id_rs_used, id_rt_used  in  1 each  source actually read
- flush_i  in  1  EX resolved taken branch/jump; kill ID instruction
- stall_i  in  1  downstream (MEM) busy; hold EX contents
- ex_valid  out  1  EX instruction real
- ex_ctrl  out  CTRL_W  registered bundle
- ex_rd1, ex_rd2, ex_imm, ex_pc2  out  DW each
- ex_rs, ex_rt, ex_wr  out  RW each
- stall_o  out  1  hold PC and IF/ID this cycle
- halted_o  out  1  processor halted (sticky)
- exc_o  out  1  illegal-opcode trap taken (sticky; see Configuration)

## Operation
- States: RUN, HALTED. Reset → RUN.
- hazard = ex_valid & ex_ctrl.MemRead & ex_ctrl.RegWrite & id_valid & ((id_rs_used & id_rs==ex_wr) | (id_rt_used & id_rt==ex_wr)).
- Per-edge priority, RUN: stall_i → hold all regs; else flush_i → load bubble; else hazard → load bubble; else load ID inputs.
- Bubble: ex_valid=0 and RegWrite, MemWrite, MemRead, Branch, Jump, RegToPc, PcToReg, Halt, SIIC, err all 0; data fields don't-care (implementation zeroes them).
- stall_o = stall_i | (hazard & ~flush_i) | halted_o (combinational).
- Capture with id_valid=0 is treated as bubble.
- Halt: a valid instruction with Halt=1 loaded into EX → next edge HALTED; HALTED keeps EX contents frozen, ignores flush_i/stall_i, exits only via rst.
- No forwarding here; the EX forwarding unit compares ex_rs/ex_rt against later stages.

## Timing
- Latency 1 cycle ID→EX.
- Reset (async, any state): ex_valid=0, ex_ctrl=0, all data outputs 0, halted_o=0, exc_o=0, stall_o reflects inputs only.
- Load-use: exactly one bubble cycle; hazard recomputes next cycle against the bubble and clears.
- flush_i with hazard same cycle: bubble, stall_o=0 (dependent instruction is dead).
- stall_i with hazard: hold; hazard re-evaluated next cycle.

## Configuration
- ID_EX_ERR_TRAP_EN defined: valid instruction with err=1 loaded into EX sets exc_o=1 and enters HALTED next edge.
- Undefined: err is carried through in ex_ctrl only; exc_o tied 0; no state change.

## Structure
- Package wisc_pkg: CTRL_W, bundle bit-position constants, ctrl bundle typedef, state encoding, BUBBLE_CTRL constant.
- Sub-module hazard_detect: combinational load-use comparator producing hazard.

## Test plan
- EX=LD r1 (MemRead, RegWrite, ex_wr=1); ID=ADD rs=1 rs_used=1 → stall_o=1 one cycle, EX gets bubble, next edge ADD in EX with id_rd1 value.
- Same hazard plus flush_i=1 → stall_o=0, EX bubble, ex_valid=0.
- stall_i=1 for 3 cycles with ID changing → ex_* unchanged, stall_o=1 throughout.
- Valid Halt enters EX → halted_o=1 next cycle; later id_valid/flush_i ignored; async rst → all outputs 0, RUN.
- ID err=1 valid: with ID_EX_ERR_TRAP_EN → exc_o=1, halted_o=1; without → exc_o=0, ex_ctrl.err=1.
- rst asserted mid-bubble with stall_i=1 → outputs zero immediately, no clock required.
